data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/dmem_pkg.sv | 18 +
 rtl/data_memory_responder_if.sv | 24 ++
 rtl/dmem_array.sv | 31 +++
 rtl/data_memory_responder.sv | 102 ++++++++++
 tb/tb_data_memory_responder.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory responder and its storage array.
package dmem_pkg;
    localparam int DATA_W          = 16;
    localparam int ADDR_W          = 16;
    localparam int CNT_W           = 4;
    localparam int LATENCY_DEF     = 2;
    localparam int DEPTH_WORDS_DEF = 256;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response bus between the MEM pipeline stage (master) and the data memory responder (slave).
interface data_memory_responder_if;
    import dmem_pkg::*;

    logic  req_valid;
    logic  req_write;
    addr_t req_addr;
    data_t req_wdata;
    logic  req_ready;
    logic  rsp_valid;
    data_t rsp_rdata;
    logic  rsp_error;
    logic  stall;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, stall
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, stall
    );
endinterface

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one combinational read port.
// Latency: write lands on the next edge, read is same-cycle.
// Backpressure: none; reset clears every word in a single edge.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH_WORDS = DEPTH_WORDS_DEF,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  data_t            wdata,
    input  logic [IDX_W-1:0] ridx,
    output data_t            rdata
);
    data_t mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];
endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency data memory responder for the MEM stage: one access in flight at a time.
// Latency: response pulse exactly LATENCY cycles after the accept cycle.
// Backpressure: req_ready only in IDLE; response has none, stall holds the upstream pipeline.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY     = LATENCY_DEF,
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    data_memory_responder_if.slave  bus
);
    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    // Byte span covered by the index field plus the byte-select bit.
    localparam int unsigned SPAN     = 32'd1 << (IDX_W + 1);
    localparam cnt_t        CNT_LOAD = cnt_t'(LATENCY - 1);

    state_t           state;
    state_t           state_nxt;
    cnt_t             cnt;
    logic             hold_write;
    addr_t            hold_addr;
    data_t            hold_wdata;
    logic             accept;
    logic             addr_err;
    logic             mem_we;
    logic [IDX_W-1:0] word_idx;
    data_t            mem_rdata;

    assign accept   = bus.req_valid && bus.req_ready;
    assign word_idx = hold_addr[IDX_W:1];
    assign addr_err = hold_addr[0] || (32'(hold_addr) >= SPAN);
    assign mem_we   = (state == RESP) && hold_write && !addr_err && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            hold_write <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else if (accept) begin
            cnt        <= CNT_LOAD;
            hold_write <= bus.req_write;
            hold_addr  <= bus.req_addr;
            hold_wdata <= bus.req_wdata;
        end else if (state == WAIT) begin
            cnt <= cnt - cnt_t'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            // Leave on the edge whose decrement reaches zero.
            WAIT: begin
                if (cnt == cnt_t'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset masks the response so an access caught in RESP is fully aborted.
    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.stall     = ((state == IDLE) && bus.req_valid) || (state == WAIT);
        bus.rsp_valid = (state == RESP) && !reset;
        bus.rsp_error = bus.rsp_valid && addr_err;
        bus.rsp_rdata = '0;
        if (bus.rsp_valid && !hold_write && !addr_err) begin
            bus.rsp_rdata = mem_rdata;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .widx  (word_idx),
        .wdata (hold_wdata),
        .ridx  (word_idx),
        .rdata (mem_rdata)
    );
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: three responders (LATENCY 2, 1, 15) sharing one clock and reset.
module tb_data_memory_responder;
    logic clk;
    logic reset;
    int   checks;
    int   fails;

    data_memory_responder_if b1 ();
    data_memory_responder_if b2 ();
    data_memory_responder_if b15 ();

    data_memory_responder #(.LATENCY(2), .DEPTH_WORDS(256)) u_l2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );
    data_memory_responder #(.LATENCY(1), .DEPTH_WORDS(256)) u_l1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );
    data_memory_responder #(.LATENCY(15), .DEPTH_WORDS(256)) u_l15 (
        .clk   (clk),
        .reset (reset),
        .bus   (b15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change at posedge+2, outputs are sampled at posedge+3.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int sel, input logic v, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        case (sel)
            1: begin
                b1.req_valid = v; b1.req_write = w; b1.req_addr = a; b1.req_wdata = d;
            end
            2: begin
                b2.req_valid = v; b2.req_write = w; b2.req_addr = a; b2.req_wdata = d;
            end
            default: begin
                b15.req_valid = v; b15.req_write = w; b15.req_addr = a; b15.req_wdata = d;
            end
        endcase
    endtask

    task automatic sample(input int sel, output logic rdy, output logic vld,
                          output logic [15:0] rd, output logic er, output logic st);
        case (sel)
            1: begin
                rdy = b1.req_ready; vld = b1.rsp_valid; rd = b1.rsp_rdata; er = b1.rsp_error; st = b1.stall;
            end
            2: begin
                rdy = b2.req_ready; vld = b2.rsp_valid; rd = b2.rsp_rdata; er = b2.rsp_error; st = b2.stall;
            end
            default: begin
                rdy = b15.req_ready; vld = b15.rsp_valid; rd = b15.rsp_rdata; er = b15.rsp_error; st = b15.stall;
            end
        endcase
    endtask

    // One access; lat = cycles from accept cycle to rsp_valid, -1 if it never came.
    task automatic access(input int sel, input logic w, input logic [15:0] a,
                          input logic [15:0] d, output logic [15:0] rd,
                          output logic er, output int lat);
        logic rdy, vld, e, st;
        logic [15:0] r;
        lat = -1;
        rd  = 16'hxxxx;
        er  = 1'bx;
        drive(sel, 1'b1, w, a, d);
        #1;
        sample(sel, rdy, vld, r, e, st);
        for (int i = 0; i < 20 && !rdy; i++) begin
            cyc();
            #1;
            sample(sel, rdy, vld, r, e, st);
        end
        if (!rdy) begin
            drive(sel, 1'b0, 1'b0, 16'h0, 16'h0);
            return;
        end
        cyc();
        // Scramble the request lines: the held copy must be what gets used.
        drive(sel, 1'b0, ~w, a ^ 16'h5a5a, ~d);
        for (int i = 1; i <= 40; i++) begin
            #1;
            sample(sel, rdy, vld, r, e, st);
            if (vld) begin
                lat = i;
                rd  = r;
                er  = e;
                break;
            end
            cyc();
        end
        cyc();
    endtask

    task automatic test_reset();
        logic rdy, vld, er, st;
        logic [15:0] rd;
        reset = 1'b1;
        drive(2, 1'b1, 1'b0, 16'h0000, 16'h0000);
        #1;
        sample(2, rdy, vld, rd, er, st);
        checks++;
        if (vld !== 1'b0) begin
            fails++; $display("FAIL reset_no_rsp: rsp_valid=%b want 0", vld);
        end
        cyc();
        reset = 1'b0;
        #1;
        sample(2, rdy, vld, rd, er, st);
        checks++;
        if (rdy !== 1'b1) begin
            fails++; $display("FAIL reset_ready: req_ready=%b want 1", rdy);
        end
        checks++;
        if (vld !== 1'b0) begin
            fails++; $display("FAIL reset_rsp_valid: rsp_valid=%b want 0", vld);
        end
        checks++;
        if (rd !== 16'h0000 || er !== 1'b0) begin
            fails++; $display("FAIL reset_rsp_idle: rdata=%h error=%b want 0000/0", rd, er);
        end
        checks++;
        if (st !== 1'b1) begin
            fails++; $display("FAIL reset_stall_follows_valid: stall=%b want 1", st);
        end
        sample(1, rdy, vld, rd, er, st);
        checks++;
        if (st !== 1'b0 || rdy !== 1'b1) begin
            fails++; $display("FAIL reset_l1_idle: stall=%b ready=%b want 0/1", st, rdy);
        end
        cyc();
        drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        sample(2, rdy, vld, rd, er, st);
        checks++;
        if (rdy !== 1'b0 || st !== 1'b1) begin
            fails++; $display("FAIL reset_held_req_accepted: ready=%b stall=%b want 0/1", rdy, st);
        end
        cyc();
        #1;
        sample(2, rdy, vld, rd, er, st);
        checks++;
        if (vld !== 1'b1 || rd !== 16'h0000 || er !== 1'b0) begin
            fails++; $display("FAIL reset_held_req_rsp: valid=%b rdata=%h error=%b want 1/0000/0", vld, rd, er);
        end
        cyc();
    endtask

    task automatic test_write_read();
        logic [15:0] rd;
        logic er;
        int lat;
        access(2, 1'b1, 16'h0010, 16'hBEEF, rd, er, lat);
        checks++;
        if (lat !== 2) begin
            fails++; $display("FAIL wr_latency: %0d cycles want 2", lat);
        end
        checks++;
        if (er !== 1'b0 || rd !== 16'h0000) begin
            fails++; $display("FAIL wr_rsp: error=%b rdata=%h want 0/0000", er, rd);
        end
        access(2, 1'b0, 16'h0010, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'hBEEF || er !== 1'b0) begin
            fails++; $display("FAIL raw_read: rdata=%h error=%b want beef/0", rd, er);
        end
        checks++;
        if (lat !== 2) begin
            fails++; $display("FAIL rd_latency: %0d cycles want 2", lat);
        end
        // 0x0010^0x5a5a was the scrambled address after the write accept.
        access(2, 1'b0, 16'h0020, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'h0000 || er !== 1'b0) begin
            fails++; $display("FAIL other_word_untouched: rdata=%h error=%b want 0000/0", rd, er);
        end
    endtask

    task automatic test_misaligned();
        logic [15:0] rd;
        logic er;
        int lat;
        access(2, 1'b0, 16'h0011, 16'h0000, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 16'h0000) begin
            fails++; $display("FAIL misaligned_read: error=%b rdata=%h want 1/0000", er, rd);
        end
        access(2, 1'b1, 16'h0011, 16'h5555, rd, er, lat);
        checks++;
        if (er !== 1'b1 || lat !== 2) begin
            fails++; $display("FAIL misaligned_write: error=%b lat=%0d want 1/2", er, lat);
        end
        access(2, 1'b0, 16'h0010, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'hBEEF || er !== 1'b0) begin
            fails++; $display("FAIL misaligned_write_suppressed: rdata=%h error=%b want beef/0", rd, er);
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] rd;
        logic er;
        int lat;
        access(2, 1'b1, 16'h0200, 16'h1234, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 16'h0000) begin
            fails++; $display("FAIL oor_write: error=%b rdata=%h want 1/0000", er, rd);
        end
        access(2, 1'b0, 16'h0000, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'h0000 || er !== 1'b0) begin
            fails++; $display("FAIL oor_write_suppressed: rdata=%h error=%b want 0000/0", rd, er);
        end
        access(2, 1'b0, 16'h8010, 16'h0000, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 16'h0000) begin
            fails++; $display("FAIL oor_read_msb: error=%b rdata=%h want 1/0000", er, rd);
        end
        access(2, 1'b0, 16'h01FE, 16'h0000, rd, er, lat);
        checks++;
        if (er !== 1'b0) begin
            fails++; $display("FAIL top_word_in_range: error=%b want 0", er);
        end
    endtask

    task automatic test_reset_mid();
        logic rdy, vld, er, st;
        logic [15:0] rd;
        int pulses;
        int lat;
        pulses = 0;
        drive(2, 1'b1, 1'b1, 16'h0004, 16'hAAAA);
        cyc();
        drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            sample(2, rdy, vld, rd, er, st);
            if (vld) pulses++;
            cyc();
            reset = 1'b0;
        end
        checks++;
        if (pulses !== 0) begin
            fails++; $display("FAIL reset_in_wait_no_rsp: %0d pulses want 0", pulses);
        end
        access(2, 1'b0, 16'h0004, 16'h0000, rd, er, lat);
        checks++;
        if (rd !== 16'h0000 || er !== 1'b0) begin
            fails++; $display("FAIL reset_in_wait_no_write: rdata=%h error=%b want 0000/0", rd, er);
        end
        // Abort while in RESP.
        drive(2, 1'b1, 1'b1, 16'h0006, 16'h7777);
        cyc();
        drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cyc();
        reset = 1'b1;
        #1;
        sample(2, rdy, vld, rd, er, st);
        checks++;
        if (vld !== 1'b0) begin
            fails++; $display("FAIL reset_in_resp_no_rsp: rsp_valid=%b want 0", vld);
        end
        cyc();
        reset = 1'b0;
        #1;
        sample(2, rdy, vld, rd, er, st);
        checks++;
        if (rdy !== 1'b1 || vld !== 1'b0) begin
            fails++; $display("FAIL reset_in_resp_idle: ready=%b valid=%b want 1/0", rdy, vld);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic rdy, vld, er, st;
        logic [15:0] rd;
        logic [7:0] st_pat, rv_pat, rdy_pat;
        int pulses, accepts;
        pulses  = 0;
        accepts = 0;
        st_pat  = '0;
        rv_pat  = '0;
        rdy_pat = '0;
        drive(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            if (i == 5) drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
            #1;
            sample(1, rdy, vld, rd, er, st);
            st_pat[i]  = st;
            rv_pat[i]  = vld;
            rdy_pat[i] = rdy;
            if (vld) pulses++;
            if (rdy && i < 5) accepts++;
            cyc();
        end
        checks++;
        if (st_pat !== 8'b0001_0101) begin
            fails++; $display("FAIL b2b_stall_pattern: %b want 00010101", st_pat);
        end
        checks++;
        if (rv_pat !== 8'b0010_1010) begin
            fails++; $display("FAIL b2b_rsp_pattern: %b want 00101010", rv_pat);
        end
        checks++;
        if (rdy_pat !== 8'b1101_0101) begin
            fails++; $display("FAIL b2b_ready_pattern: %b want 11010101", rdy_pat);
        end
        checks++;
        if (pulses !== 3 || accepts !== 3) begin
            fails++; $display("FAIL b2b_counts: pulses=%0d accepts=%0d want 3/3", pulses, accepts);
        end
    endtask

    task automatic test_latency15();
        logic rdy, vld, er, st;
        logic [15:0] rd;
        int stall_cnt, rsp_at, pulses;
        logic st_at;
        stall_cnt = 0;
        rsp_at    = -1;
        pulses    = 0;
        st_at     = 1'bx;
        drive(15, 1'b1, 1'b0, 16'h0002, 16'h0000);
        for (int i = 0; i < 25; i++) begin
            if (i == 1) drive(15, 1'b0, 1'b0, 16'h0000, 16'h0000);
            #1;
            sample(15, rdy, vld, rd, er, st);
            if (vld) begin
                pulses++;
                if (rsp_at < 0) begin
                    rsp_at = i;
                    st_at  = st;
                end
            end else if (st && rsp_at < 0) begin
                stall_cnt++;
            end
            cyc();
        end
        checks++;
        if (stall_cnt !== 15) begin
            fails++; $display("FAIL l15_stall_cycles: %0d want 15", stall_cnt);
        end
        checks++;
        if (rsp_at !== 15) begin
            fails++; $display("FAIL l15_rsp_cycle: %0d want 15", rsp_at);
        end
        checks++;
        if (st_at !== 1'b0) begin
            fails++; $display("FAIL l15_stall_in_resp: %b want 0", st_at);
        end
        checks++;
        if (pulses !== 1) begin
            fails++; $display("FAIL l15_pulses: %0d want 1", pulses);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        reset  = 1'b1;
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(15, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cyc();
        test_reset();
        test_write_read();
        test_misaligned();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        test_latency15();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
